// File: rtl/cmos_capture_pack.sv
`default_nettype none
// ============================================================================
// Module      : cmos_capture_pack
// Description : Captures 8-bit CMOS sensor bytes, packs byte pairs into
//               RGB565 words and writes them to a FIFO in the pixel-clock
//               domain. Discards a number of frames after start for sensor
//               settling, checks line/frame geometry and counts good frames.
// Ports       : clk_write       - pixel clock / FIFO write clock
//               rst             - asynchronous active-high reset
//               cam_vsync       - high = vertical blanking, fall = frame start
//               cam_href        - high = active line bytes present
//               cam_data[7:0]   - sensor byte
//               capture_en      - capture request (level)
//               sdram_init_done - SDRAM ready, asynchronous to clk_write
//               sys_we          - FIFO write strobe, one cycle per word
//               sys_data_in     - packed RGB565 word
//               wr_load         - one-cycle SDRAM write-address reset
//               frame_cnt[7:0]  - good frames captured (wraps)
//               frame_err       - one-cycle pulse on a malformed frame
//               line_err        - sticky malformed-line flag
//               busy            - high while a frame is being captured
// Revision    : 1.0 - initial release
// ============================================================================
module cmos_capture_pack #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk_write,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    input  logic        sdram_init_done,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic        wr_load,
    output logic [7:0]  frame_cnt,
    output logic        frame_err,
    output logic        line_err,
    output logic        busy
);

    localparam logic [9:0] c_h_pixels    = 10'(H_PIXELS);
    localparam logic [9:0] c_v_lines     = 10'(V_LINES);
    localparam logic [7:0] c_skip_frames = 8'(SKIP_FRAMES);

    localparam logic [1:0] c_s_idle    = 2'd0;
    localparam logic [1:0] c_s_settle  = 2'd1;
    localparam logic [1:0] c_s_wait_vs = 2'd2;
    localparam logic [1:0] c_s_active  = 2'd3;

    // Input register stage and its delayed copy for edge detection
    logic        r_vs, r_vs_d, r_href, r_href_d;
    logic [7:0]  r_data;
    // SDRAM-ready synchronizer
    logic        r_init_m, r_init_s;
    // Control state
    logic [1:0]  r_state, w_state_nxt;
    logic [7:0]  r_skip_cnt;
    // Packing / geometry state
    logic        r_phase, r_line_valid, r_frame_bad;
    logic [7:0]  r_hi;
    logic [9:0]  r_pix_cnt, r_line_cnt;
    logic        r_we_pre;
    logic [15:0] r_word_pre;
    // Registered outputs
    logic        r_sys_we, r_wr_load, r_frame_err, r_line_err;
    logic [15:0] r_sys_data;
    logic [7:0]  r_frame_cnt;

    logic        w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
    logic        w_active, w_frame_start, w_frame_end, w_frame_good;
    logic        w_byte_ok, w_eff_phase, w_pix_full, w_line_over;
    logic        w_ovf_err, w_fall_err;
    logic [9:0]  w_eff_pix;

    assign w_vs_rise   =  r_vs   & ~r_vs_d;
    assign w_vs_fall   = ~r_vs   &  r_vs_d;
    assign w_href_rise =  r_href & ~r_href_d;
    assign w_href_fall = ~r_href &  r_href_d;

    // Loss of SDRAM readiness overrides every state, so it gates activity too
    assign w_active      = (r_state == c_s_active) && r_init_s;
    assign w_frame_start = (r_state == c_s_wait_vs) && r_init_s && w_vs_fall;
    assign w_frame_end   = w_active && w_vs_rise;
    assign w_frame_good  = (r_line_cnt == c_v_lines) && !r_frame_bad;

    // A byte counts only inside a line that started with an href rise while
    // capturing; a line already running at frame start is ignored.
    assign w_byte_ok   = w_active && r_href && (w_href_rise || r_line_valid);
    // At href rise the current byte is the first of a fresh line
    assign w_eff_phase = w_href_rise ? 1'b0 : r_phase;
    assign w_eff_pix   = w_href_rise ? 10'd0 : r_pix_cnt;
    assign w_pix_full  = (w_eff_pix == c_h_pixels);
    assign w_line_over = (r_line_cnt >= c_v_lines);
    assign w_ovf_err   = w_byte_ok && w_pix_full;
    assign w_fall_err  = w_active && r_line_valid && w_href_fall &&
                         (r_phase || (r_pix_cnt != c_h_pixels));

    always_comb begin
        w_state_nxt = r_state;
        if (!r_init_s) begin
            w_state_nxt = c_s_idle;
        end else begin
            case (r_state)
                c_s_idle:    if (capture_en) w_state_nxt = c_s_settle;
                c_s_settle:  if (r_skip_cnt == c_skip_frames) w_state_nxt = c_s_wait_vs;
                c_s_wait_vs: if (w_vs_fall) w_state_nxt = c_s_active;
                c_s_active:  if (w_vs_rise) w_state_nxt = capture_en ? c_s_wait_vs : c_s_idle;
                default:     w_state_nxt = c_s_idle;
            endcase
        end
    end

    always_ff @(posedge clk_write or posedge rst) begin
        if (rst) begin
            r_vs       <= 1'b0;
            r_vs_d     <= 1'b0;
            r_href     <= 1'b0;
            r_href_d   <= 1'b0;
            r_data     <= 8'h00;
            r_init_m   <= 1'b0;
            r_init_s   <= 1'b0;
            r_state    <= c_s_idle;
            r_skip_cnt <= 8'd0;
        end else begin
            r_vs       <= cam_vsync;
            r_vs_d     <= r_vs;
            r_href     <= cam_href;
            r_href_d   <= r_href;
            r_data     <= cam_data;
            r_init_m   <= sdram_init_done;
            r_init_s   <= r_init_m;
            r_state    <= w_state_nxt;
            if (r_state != c_s_settle)
                r_skip_cnt <= 8'd0;
            else if (w_vs_rise && (r_skip_cnt != c_skip_frames))
                r_skip_cnt <= r_skip_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_write or posedge rst) begin
        if (rst) begin
            r_phase      <= 1'b0;
            r_line_valid <= 1'b0;
            r_frame_bad  <= 1'b0;
            r_hi         <= 8'h00;
            r_pix_cnt    <= 10'd0;
            r_line_cnt   <= 10'd0;
            r_we_pre     <= 1'b0;
            r_word_pre   <= 16'h0000;
            r_sys_we     <= 1'b0;
            r_sys_data   <= 16'h0000;
            r_wr_load    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_line_err   <= 1'b0;
        end else begin
            r_we_pre <= 1'b0;
            if (w_frame_start) begin
                r_line_cnt   <= 10'd0;
                r_pix_cnt    <= 10'd0;
                r_frame_bad  <= 1'b0;
                r_phase      <= 1'b0;
                r_line_valid <= 1'b0;
            end else if (!w_active) begin
                // Any partial byte pair is abandoned outside capture
                r_phase      <= 1'b0;
                r_line_valid <= 1'b0;
            end else if (w_href_fall && r_line_valid) begin
                r_line_cnt   <= r_line_cnt + 10'd1;
                r_line_valid <= 1'b0;
                r_phase      <= 1'b0;
            end else if (w_byte_ok) begin
                r_line_valid <= 1'b1;
                if (w_pix_full) begin
                    // Line already complete: surplus bytes are dropped
                    r_pix_cnt <= w_eff_pix;
                    r_phase   <= 1'b0;
                end else if (!w_eff_phase) begin
                    r_hi      <= r_data;
                    r_phase   <= 1'b1;
                    r_pix_cnt <= w_eff_pix;
                end else begin
                    r_word_pre <= {r_hi, r_data};
                    r_we_pre   <= !w_line_over;
                    r_phase    <= 1'b0;
                    r_pix_cnt  <= w_eff_pix + 10'd1;
                end
            end

            if (w_ovf_err || w_fall_err) begin
                r_line_err  <= 1'b1;
                r_frame_bad <= 1'b1;
            end

            // Word staged one cycle earlier is dropped if readiness was lost
            r_sys_we <= r_we_pre && r_init_s;
            if (r_we_pre && r_init_s)
                r_sys_data <= r_word_pre;

            r_wr_load   <= w_frame_start;
            r_frame_err <= w_frame_end && !w_frame_good;
            if (w_frame_end && w_frame_good)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign sys_we      = r_sys_we;
    assign sys_data_in = r_sys_data;
    assign wr_load     = r_wr_load;
    assign frame_cnt   = r_frame_cnt;
    assign frame_err   = r_frame_err;
    assign line_err    = r_line_err;
    assign busy        = (r_state == c_s_active);

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmos_capture_pack
// Description : Self-checking bench for cmos_capture_pack. Expected words are
//               queued as bytes are driven and compared as the DUT writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_capture_pack;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int SKIP = 1;

    logic        clk_write = 1'b0;
    logic        rst;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        capture_en;
    logic        sdram_init_done;
    logic        sys_we;
    logic [15:0] sys_data_in;
    logic        wr_load;
    logic [7:0]  frame_cnt;
    logic        frame_err;
    logic        line_err;
    logic        busy;

    cmos_capture_pack #(
        .H_PIXELS    (H),
        .V_LINES     (V),
        .SKIP_FRAMES (SKIP)
    ) u_dut (
        .clk_write       (clk_write),
        .rst             (rst),
        .cam_vsync       (cam_vsync),
        .cam_href        (cam_href),
        .cam_data        (cam_data),
        .capture_en      (capture_en),
        .sdram_init_done (sdram_init_done),
        .sys_we          (sys_we),
        .sys_data_in     (sys_data_in),
        .wr_load         (wr_load),
        .frame_cnt       (frame_cnt),
        .frame_err       (frame_err),
        .line_err        (line_err),
        .busy            (busy)
    );

    always #5 clk_write = ~clk_write;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          we_cnt   = 0;
    int          wl_cnt   = 0;
    int          fe_cnt   = 0;
    int          first_we = -1;
    int          t34      = -1;
    bit          arm      = 1'b0;
    logic [7:0]  nxt      = 8'h12;
    logic [15:0] last_exp = 16'h0000;
    logic [15:0] exp_q[$];

    always @(posedge clk_write) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk_write) begin
        if (rst === 1'b0) begin
            if (wr_load)   wl_cnt++;
            if (frame_err) fe_cnt++;
            if (sys_we) begin
                we_cnt++;
                if (first_we < 0) first_we = cyc;
                if (exp_q.size() == 0)
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                else
                    check("sb_word", 32'(sys_data_in), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_write);
        #1;
    endtask

    // One line of n bytes; pairs become words while the line and word index
    // are within the frame geometry and the frame is expected to be captured.
    task automatic drive_line(input int nbytes, input bit cap, input int lidx);
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            cam_href = 1'b1;
            cam_data = nxt;
            if (arm && nxt == 8'h34) begin
                t34 = cyc;
                arm = 1'b0;
            end
            if (i % 2 == 0) begin
                hi = nxt;
            end else if (cap && (i / 2) < H && lidx < V) begin
                exp_q.push_back({hi, nxt});
                last_exp = {hi, nxt};
            end
            nxt = nxt + 8'h22;
            tick(1);
        end
        cam_href = 1'b0;
        tick(3);
    endtask

    task automatic run_frame(input int len0, input int len1, input bit cap);
        cam_vsync = 1'b0;
        tick(4);
        drive_line(len0, cap, 0);
        drive_line(len1, cap, 1);
        tick(2);
        cam_vsync = 1'b1;
        tick(8);
    endtask

    int wl0, we0, fe0;

    initial begin
        rst             = 1'b1;
        cam_vsync       = 1'b1;
        cam_href        = 1'b0;
        cam_data        = 8'h00;
        capture_en      = 1'b0;
        sdram_init_done = 1'b0;
        tick(3);

        // Reset state
        check("rst_sys_we",    32'(sys_we),      32'd0);
        check("rst_data",      32'(sys_data_in), 32'd0);
        check("rst_wr_load",   32'(wr_load),     32'd0);
        check("rst_frame_cnt", 32'(frame_cnt),   32'd0);
        check("rst_frame_err", 32'(frame_err),   32'd0);
        check("rst_line_err",  32'(line_err),    32'd0);
        check("rst_busy",      32'(busy),        32'd0);

        rst = 1'b0;
        tick(2);
        sdram_init_done = 1'b1;
        capture_en      = 1'b1;
        tick(5);

        // Nominal: one skipped frame, then a captured frame
        run_frame(8, 8, 1'b0);
        check("skip_no_wr_load", 32'(wl_cnt), 32'd0);
        check("skip_no_we",      32'(we_cnt), 32'd0);
        nxt      = 8'h12;
        arm      = 1'b1;
        first_we = -1;
        run_frame(8, 8, 1'b1);
        check("nom_wr_load",   32'(wl_cnt),            32'd1);
        check("nom_we_cnt",    32'(we_cnt),            32'd8);
        // byte 34h driven after edge t34 is sampled at t34+1; word two edges later
        check("nom_latency",   32'(first_we - t34),    32'd3);
        check("nom_frame_cnt", 32'(frame_cnt),         32'd1);
        check("nom_frame_err", 32'(fe_cnt),            32'd0);
        check("nom_line_err",  32'(line_err),          32'd0);
        check("nom_hold_data", 32'(sys_data_in),       32'(last_exp));
        check("nom_q_empty",   32'(exp_q.size()),      32'd0);

        // capture_en dropped mid-frame: frame completes, then idle
        wl0 = wl_cnt; we0 = we_cnt;
        cam_vsync = 1'b0;
        tick(4);
        check("cen_busy", 32'(busy), 32'd1);
        drive_line(8, 1'b1, 0);
        capture_en = 1'b0;
        drive_line(8, 1'b1, 1);
        tick(2);
        cam_vsync = 1'b1;
        tick(8);
        check("cen_frame_cnt", 32'(frame_cnt),       32'd2);
        check("cen_idle",      32'(busy),            32'd0);
        check("cen_we_cnt",    32'(we_cnt - we0),    32'd8);
        run_frame(8, 8, 1'b0);
        check("cen_no_wr_load", 32'(wl_cnt - wl0),   32'd1);
        check("cen_no_we",      32'(we_cnt - we0),   32'd8);

        // SDRAM init drop mid-line
        capture_en = 1'b1;
        tick(2);
        run_frame(8, 8, 1'b0);
        wl0 = wl_cnt;
        cam_vsync = 1'b0;
        tick(4);
        drive_line(8, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            cam_href = 1'b1;
            cam_data = nxt;
            if (i == 1) exp_q.push_back({nxt - 8'h22, nxt});
            if (i == 2) sdram_init_done = 1'b0;
            nxt = nxt + 8'h22;
            tick(1);
            if (i == 4) begin
                check("drop_we_off", 32'(sys_we), 32'd0);
                check("drop_idle",   32'(busy),   32'd0);
            end
        end
        cam_href = 1'b0;
        tick(3);
        drive_line(8, 1'b0, 1);
        tick(2);
        cam_vsync = 1'b1;
        tick(8);
        check("drop_wr_load",   32'(wl_cnt - wl0),  32'd1);
        check("drop_frame_cnt", 32'(frame_cnt),     32'd2);
        check("drop_q_empty",   32'(exp_q.size()),  32'd0);
        sdram_init_done = 1'b1;
        tick(5);
        run_frame(8, 8, 1'b0);
        check("drop_resettle",  32'(wl_cnt - wl0),  32'd1);
        run_frame(8, 8, 1'b1);
        check("drop_recover_wl", 32'(wl_cnt - wl0), 32'd2);
        check("drop_recover_fc", 32'(frame_cnt),    32'd3);

        // Odd-length line
        we0 = we_cnt; fe0 = fe_cnt;
        run_frame(7, 8, 1'b1);
        check("odd_we_cnt",    32'(we_cnt - we0), 32'd7);
        check("odd_line_err",  32'(line_err),     32'd1);
        check("odd_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("odd_frame_cnt", 32'(frame_cnt),    32'd3);

        // Asynchronous reset mid-line
        cam_vsync = 1'b0;
        tick(4);
        check("arst_busy_pre", 32'(busy), 32'd1);
        cam_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cam_data = nxt;
            nxt = nxt + 8'h22;
            tick(1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_sys_we",    32'(sys_we),      32'd0);
        check("arst_data",      32'(sys_data_in), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt),   32'd0);
        check("arst_line_err",  32'(line_err),    32'd0);
        check("arst_busy",      32'(busy),        32'd0);
        check("arst_frame_err", 32'(frame_err),   32'd0);
        check("arst_wr_load",   32'(wr_load),     32'd0);
        exp_q.delete();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);

        // Overlong line after restart (settling repeats)
        wl0 = wl_cnt; we0 = we_cnt; fe0 = fe_cnt;
        run_frame(8, 8, 1'b0);
        check("ovl_settle_wl", 32'(wl_cnt - wl0), 32'd0);
        run_frame(10, 8, 1'b1);
        check("ovl_wr_load",   32'(wl_cnt - wl0),  32'd1);
        check("ovl_we_cnt",    32'(we_cnt - we0),  32'd8);
        check("ovl_line_err",  32'(line_err),      32'd1);
        check("ovl_frame_err", 32'(fe_cnt - fe0),  32'd1);
        check("ovl_frame_cnt", 32'(frame_cnt),     32'd0);
        check("ovl_q_empty",   32'(exp_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
